// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RISC-V style control FSM driving a shared-memory datapath.
// Optional CTRL_ILLEGAL_TRAP_EN: unknown opcodes raise sticky illegal and halt instead of acting as NOP.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] aluop,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       halted,
    output logic       illegal,
    output logic [3:0] state
);
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXEC   = 4'd2;
    localparam logic [3:0] S_ADDR   = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_WBMEM  = 4'd6;
    localparam logic [3:0] S_WBALU  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_HALT   = 4'd10;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_HALT = 7'b1111111;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       r_halted;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam logic [3:0] S_UNKNOWN = S_HALT;
    logic w_unknown;
    logic r_illegal;
    always_comb
        w_unknown = !(opcode == OP_R || opcode == OP_I || opcode == OP_LD || opcode == OP_ST ||
                      opcode == OP_BR || opcode == OP_JAL || opcode == OP_JALR || opcode == OP_HALT);
    always_ff @(posedge clk or posedge rst)
        if (rst)
            r_illegal <= 1'b0;
        else if (r_state == S_DECODE && w_unknown)
            r_illegal <= 1'b1;
    assign illegal = r_illegal;
`else
    // Unknown opcodes fall back to FETCH; the PC was already advanced during the fetch.
    localparam logic [3:0] S_UNKNOWN = S_FETCH;
    assign illegal = 1'b0;
`endif

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: w_next = (opcode == OP_R || opcode == OP_I)     ? S_EXEC   :
                               (opcode == OP_LD || opcode == OP_ST)   ? S_ADDR   :
                               (opcode == OP_BR)                      ? S_BRANCH :
                               (opcode == OP_JAL || opcode == OP_JALR) ? S_JUMP  :
                               (opcode == OP_HALT)                    ? S_HALT   : S_UNKNOWN;
            S_EXEC:   w_next = S_WBALU;
            S_ADDR:   w_next = (opcode == OP_LD) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = mem_ready ? S_WBMEM : S_MEMRD;
            S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state  <= S_FETCH;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_next;
            if (w_next == S_HALT)
                r_halted <= 1'b1;
        end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'b00;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        aluop     = 2'b00;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b10;
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = (opcode == OP_R) ? 2'b00 : 2'b10;
                aluop     = (opcode == OP_R) ? 2'b10 : 2'b11;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = 1'b1;
            end
            S_WBMEM: begin
                reg_write = 1'b1;
                wb_sel    = 2'b01;
            end
            S_WBALU: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                aluop     = 2'b01;
                pc_src    = 2'b01;
                pc_write  = (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero);
            end
            S_JUMP: begin
                reg_write = 1'b1;
                wb_sel    = 2'b10;
                pc_write  = 1'b1;
                pc_src    = (opcode == OP_JALR) ? 2'b10 : 2'b01;
                alu_src_a = (opcode == OP_JALR);
                alu_src_b = (opcode == OP_JALR) ? 2'b10 : 2'b00;
            end
            default: ;
        endcase
    end

    assign halted = r_halted;
    assign state  = r_state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scoreboard bench for multicycle_ctrl.
module tb_multicycle_ctrl;
    typedef logic [20:0] vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write, alu_src_a, reg_write, halted, illegal;
    logic [1:0] pc_src, alu_src_b, aluop, wb_sel;
    logic [3:0] state;

    int   errors = 0;
    int   checks = 0;
    vec_t  exp_q[$];
    string tag_q[$];

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .aluop(aluop), .reg_write(reg_write), .wb_sel(wb_sel),
        .halted(halted), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] st, input logic mreq, we, io, irw, pcw,
                                input logic [1:0] pcs, input logic asa, input logic [1:0] asb, aop,
                                input logic rw, input logic [1:0] wbs, input logic h, il);
        return {st, mreq, we, io, irw, pcw, pcs, asa, asb, aop, rw, wbs, h, il};
    endfunction

    function automatic vec_t e_fetch(input logic mr);
        return mk(4'd0, 1, 0, 0, mr, mr, 2'b00, 0, 2'b01, 2'b00, 0, 2'b00, 0, 0);
    endfunction
    function automatic vec_t e_decode();
        return mk(4'd1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 2'b00, 0, 2'b00, 0, 0);
    endfunction
    function automatic vec_t e_exec(input logic r);
        return mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 1, r ? 2'b00 : 2'b10, r ? 2'b10 : 2'b11, 0, 2'b00, 0, 0);
    endfunction
    function automatic vec_t e_addr();
        return mk(4'd3, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 2'b00, 0, 0);
    endfunction
    function automatic vec_t e_mem(input logic wr);
        return mk(wr ? 4'd5 : 4'd4, 1, wr, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0);
    endfunction
    function automatic vec_t e_wb(input logic mem);
        return mk(mem ? 4'd6 : 4'd7, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, mem ? 2'b01 : 2'b00, 0, 0);
    endfunction
    function automatic vec_t e_branch(input logic take);
        return mk(4'd8, 0, 0, 0, 0, take, 2'b01, 1, 2'b00, 2'b01, 0, 2'b00, 0, 0);
    endfunction
    function automatic vec_t e_jump(input logic jalr);
        return mk(4'd9, 0, 0, 0, 0, 1, jalr ? 2'b10 : 2'b01, jalr, jalr ? 2'b10 : 2'b00, 2'b00, 1, 2'b10, 0, 0);
    endfunction
    function automatic vec_t e_halt(input logic il);
        return mk(4'd10, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 1, il);
    endfunction

    task automatic check();
        vec_t  e, o;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = {state, mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
             aluop, reg_write, wb_sel, halted, illegal};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", t, o, e);
        end
    endtask

    // Drive one cycle at the falling edge, check mid-cycle, then advance past the next rising edge.
    task automatic cyc(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic z, input logic mr, input vec_t e);
        opcode = op;
        funct3 = f3;
        zero = z;
        mem_ready = mr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1 check();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic async_rst(input string tag);
        mem_ready = 1'b0;
        #2 rst = 1'b1;
        exp_q.push_back(e_fetch(1'b0));
        tag_q.push_back(tag);
        #1 check();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_q.push_back(e_fetch(1'b0));
        tag_q.push_back("reset");
        #1 check();
        @(negedge clk);
        rst = 1'b0;

        cyc("add_fetch",  7'b0110011, 3'd0, 0, 1, e_fetch(1));
        cyc("add_decode", 7'b0110011, 3'd0, 0, 0, e_decode());
        cyc("add_exec",   7'b0110011, 3'd0, 0, 0, e_exec(1));
        cyc("add_wbalu",  7'b0110011, 3'd0, 0, 0, e_wb(0));

        for (int i = 0; i < 3; i++)
            cyc("lw_fetch_wait", 7'b0000011, 3'd2, 0, 0, e_fetch(0));
        cyc("lw_fetch_done", 7'b0000011, 3'd2, 0, 1, e_fetch(1));
        cyc("lw_decode",     7'b0000011, 3'd2, 0, 1, e_decode());
        cyc("lw_addr",       7'b0000011, 3'd2, 0, 1, e_addr());
        cyc("lw_memrd_wait", 7'b0000011, 3'd2, 0, 0, e_mem(0));
        cyc("lw_memrd_done", 7'b0000011, 3'd2, 0, 1, e_mem(0));
        cyc("lw_wbmem",      7'b0000011, 3'd2, 0, 1, e_wb(1));

        cyc("sw_fetch",      7'b0100011, 3'd2, 0, 1, e_fetch(1));
        cyc("sw_decode",     7'b0100011, 3'd2, 0, 0, e_decode());
        cyc("sw_addr",       7'b0100011, 3'd2, 0, 0, e_addr());
        cyc("sw_memwr_wait", 7'b0100011, 3'd2, 0, 0, e_mem(1));
        cyc("sw_memwr_done", 7'b0100011, 3'd2, 0, 1, e_mem(1));

        cyc("addi_fetch",  7'b0010011, 3'd0, 0, 1, e_fetch(1));
        cyc("addi_decode", 7'b0010011, 3'd0, 0, 0, e_decode());
        cyc("addi_exec",   7'b0010011, 3'd0, 0, 0, e_exec(0));
        cyc("addi_wbalu",  7'b0010011, 3'd0, 0, 0, e_wb(0));

        cyc("beq_t_fetch",  7'b1100011, 3'b000, 1, 1, e_fetch(1));
        cyc("beq_t_decode", 7'b1100011, 3'b000, 1, 0, e_decode());
        cyc("beq_taken",    7'b1100011, 3'b000, 1, 0, e_branch(1));
        cyc("beq_n_fetch",  7'b1100011, 3'b000, 0, 1, e_fetch(1));
        cyc("beq_n_decode", 7'b1100011, 3'b000, 0, 0, e_decode());
        cyc("beq_not",      7'b1100011, 3'b000, 0, 0, e_branch(0));
        cyc("f100_fetch",   7'b1100011, 3'b100, 1, 1, e_fetch(1));
        cyc("f100_decode",  7'b1100011, 3'b100, 1, 0, e_decode());
        cyc("f100_branch",  7'b1100011, 3'b100, 1, 0, e_branch(0));
        cyc("bne_fetch",    7'b1100011, 3'b001, 0, 1, e_fetch(1));
        cyc("bne_decode",   7'b1100011, 3'b001, 0, 0, e_decode());
        cyc("bne_taken",    7'b1100011, 3'b001, 0, 0, e_branch(1));

        cyc("jal_fetch",   7'b1101111, 3'd0, 0, 1, e_fetch(1));
        cyc("jal_decode",  7'b1101111, 3'd0, 0, 0, e_decode());
        cyc("jal_jump",    7'b1101111, 3'd0, 0, 0, e_jump(0));
        cyc("jalr_fetch",  7'b1100111, 3'd0, 0, 1, e_fetch(1));
        cyc("jalr_decode", 7'b1100111, 3'd0, 0, 0, e_decode());
        cyc("jalr_jump",   7'b1100111, 3'd0, 0, 0, e_jump(1));

        cyc("abort_fetch",  7'b0000011, 3'd2, 0, 1, e_fetch(1));
        cyc("abort_decode", 7'b0000011, 3'd2, 0, 0, e_decode());
        cyc("abort_addr",   7'b0000011, 3'd2, 0, 0, e_addr());
        cyc("abort_memrd",  7'b0000011, 3'd2, 0, 0, e_mem(0));
        async_rst("abort_rst");
        cyc("refetch",      7'b0110011, 3'd0, 0, 1, e_fetch(1));
        cyc("refetch_dec",  7'b0110011, 3'd0, 0, 0, e_decode());
        cyc("refetch_exec", 7'b0110011, 3'd0, 0, 0, e_exec(1));
        cyc("refetch_wb",   7'b0110011, 3'd0, 0, 0, e_wb(0));

        cyc("halt_fetch",  7'b1111111, 3'd0, 0, 1, e_fetch(1));
        cyc("halt_decode", 7'b1111111, 3'd0, 0, 1, e_decode());
        cyc("halt_state",  7'b1111111, 3'd0, 0, 1, e_halt(0));
        cyc("halt_stay",   7'b0110011, 3'd0, 0, 1, e_halt(0));
        async_rst("halt_rst");

        cyc("unk_fetch",  7'b0000000, 3'd0, 0, 1, e_fetch(1));
        cyc("unk_decode", 7'b0000000, 3'd0, 0, 0, e_decode());
`ifdef CTRL_ILLEGAL_TRAP_EN
        cyc("unk_trap",   7'b0000000, 3'd0, 0, 1, e_halt(1));
        cyc("unk_stay",   7'b0110011, 3'd0, 0, 1, e_halt(1));
`else
        cyc("unk_nop",    7'b0000000, 3'd0, 0, 0, e_fetch(0));
        cyc("unk_next",   7'b0110011, 3'd0, 0, 1, e_fetch(1));
        cyc("unk_next_d", 7'b0110011, 3'd0, 0, 0, e_decode());
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk  in  1  sole clock, rising edge.
REQ-002 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port opcode  in  7  instr[6:0] from instruction register.
REQ-004 SHALL have port funct3  in  3  instr[14:12].
REQ-005 SHALL have port zero  in  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  in  1  shared memory completes current access this cycle.
REQ-007 SHALL have port mem_req  out  1  memory access request.
REQ-008 SHALL have port mem_we  out  1  request is a write.
REQ-009 SHALL have port iord  out  1  0=address from PC, 1=address from ALU result register.
REQ-010 SHALL have port ir_write  out  1  load instruction register.
REQ-011 SHALL have port pc_write  out  1  update PC.
REQ-012 SHALL have port pc_src  out  2  00=ALU result (PC+4), 01=target register, 10=ALU result with bit0 cleared (JALR).
REQ-013 SHALL have port alu_src_a  out  1  0=PC, 1=rs1.
REQ-014 SHALL have port alu_src_b  out  2  00=rs2, 01=constant 4, 10=immediate.
REQ-015 SHALL have port aluop  out  2  00 add, 01 branch-compare, 10 R-type, 11 I-type.
REQ-016 SHALL have port reg_write  out  1  register file write enable.
REQ-017 SHALL have port wb_sel  out  2  00=ALU result register, 01=memory data register, 10=PC.
REQ-018 SHALL have port halted  out  1  sticky, processor stopped.
REQ-019 SHALL have port illegal  out  1  sticky, unknown opcode decoded.
REQ-020 SHALL have port state  out  4  current state encoding, for debug.

Function
REQ-021 SHALL implement states FETCH=0, DECODE=1, EXEC=2, ADDR=3, MEMRD=4, MEMWR=5, WBMEM=6, WBALU=7, BRANCH=8, JUMP=9, HALT=10; codes 11-15 SHALL go to FETCH next cycle with all enables low.
REQ-022 FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, aluop=00; ir_write, pc_write and pc_src=00 SHALL assert only in a cycle where mem_ready=1; next state is DECODE on mem_ready, otherwise FETCH.
REQ-023 DECODE (1 cycle): alu_src_a=0, alu_src_b=10, aluop=00, computing the branch/JAL target into the target register. Next state: 0110011 or 0010011 -> EXEC; 0000011 or 0100011 -> ADDR; 1100011 -> BRANCH; 1101111 or 1100111 -> JUMP; 1111111 -> HALT; any other opcode -> see REQ-035.
REQ-024 EXEC: alu_src_a=1, alu_src_b=00 (R-type, aluop=10) or 10 (I-type, aluop=11); next WBALU.
REQ-025 ADDR: alu_src_a=1, alu_src_b=10, aluop=00; next MEMRD for 0000011, MEMWR for 0100011.
REQ-026 MEMRD/MEMWR: mem_req=1, iord=1, mem_we=1 only in MEMWR; each SHALL hold until mem_ready=1; MEMRD then goes to WBMEM, MEMWR to FETCH.
REQ-027 WBMEM: reg_write=1, wb_sel=01. WBALU: reg_write=1, wb_sel=00. Both then go to FETCH.
REQ-028 BRANCH: alu_src_a=1, alu_src_b=00, aluop=01, pc_src=01; pc_write=1 iff (funct3=000 and zero=1) or (funct3=001 and zero=0); other funct3 SHALL NOT branch; next FETCH.
REQ-029 JUMP: reg_write=1, wb_sel=10, pc_write=1; JAL pc_src=01; JALR pc_src=10 with alu_src_a=1, alu_src_b=10, aluop=00; next FETCH.
REQ-030 HALT: absorbing state, halted=1, all enables and mem_req low.
REQ-031 mem_req SHALL remain asserted with constant iord/mem_we from request until the mem_ready cycle; mem_ready outside FETCH/MEMRD/MEMWR SHALL be ignored.
REQ-032 Outputs not listed for a state SHALL be 0.

Reset
REQ-033 rst=1 SHALL force state=FETCH, halted=0, illegal=0 immediately, without waiting for clk.
REQ-034 rst asserted mid-access SHALL abandon the access; with FETCH outputs active, the new fetch is issued on the first clk edge after rst deasserts.

Configuration
REQ-035 Macro CTRL_ILLEGAL_TRAP_EN defined: an unknown opcode in DECODE SHALL set illegal=1 and go to HALT. Not defined: the unknown opcode SHALL act as a NOP (DECODE -> FETCH, PC already advanced) and illegal SHALL be tied 0.

Verification
REQ-036 add (0110011), mem_ready=1 in fetch -> FETCH, DECODE, EXEC, WBALU, 4 cycles, reg_write=1 only in the WBALU cycle.
REQ-037 lw (0000011), fetch mem_ready delayed 3 cycles -> mem_req held for 4 FETCH cycles, ir_write exactly once, then DECODE, ADDR, MEMRD, WBMEM with wb_sel=01.
REQ-038 beq funct3=000 with zero=1 -> pc_write=1, pc_src=01 in BRANCH; with zero=0 -> pc_write=0; funct3=100 -> pc_write=0.
REQ-039 opcode 1111111 -> HALT, halted=1, no mem_req on later clocks; rst pulse -> state=0 asynchronously.
REQ-040 opcode 0000000 -> illegal=1 and halted when CTRL_ILLEGAL_TRAP_EN is defined; returns to FETCH with illegal=0 when it is not defined.
